decoder_nxm_seq: RTL and testbench

DECODER_NXM_SEQ -- requirements
Module: decoder_nxm_seq

---
 rtl/decoder_pkg.sv | 18 +
 rtl/decoder_nxm_seq_if.sv | 30 +++
 rtl/scan_prescaler.sv | 40 ++++
 rtl/decoder_nxm_seq.sv | 118 +++++++++++
 tb/tb_decoder_nxm_seq.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/decoder_pkg.sv
// Shared encodings for decoder_nxm_seq.
//   mode_e  : 2-bit operating mode presented on the bus interface
//   state_e : decoder state (IDLE = outputs inactive, ACTIVE = one-hot of idx)
package decoder_pkg;

  typedef enum logic [1:0] {
    ModeDecode   = 2'b00,
    ModeScanUp   = 2'b01,
    ModeScanDown = 2'b10,
    ModeHold     = 2'b11
  } mode_e;

  typedef enum logic {
    StIdle   = 1'b0,
    StActive = 1'b1
  } state_e;

endpackage

// File: rtl/decoder_nxm_seq_if.sv
// Bus interface for decoder_nxm_seq.
//   master : drives en, mode, sel, sel_valid; observes sel_ready, y, y_valid, idx, wrap
//   slave  : the decoder side (opposite directions)
interface decoder_nxm_seq_if #(
  parameter int unsigned SEL_W = 2,
  parameter int unsigned OUT_W = 2 ** SEL_W
);
  import decoder_pkg::*;

  logic             en;
  mode_e            mode;
  logic [SEL_W-1:0] sel;
  logic             sel_valid;
  logic             sel_ready;
  logic [OUT_W-1:0] y;
  logic             y_valid;
  logic [SEL_W-1:0] idx;
  logic             wrap;

  modport master (
    output en, mode, sel, sel_valid,
    input  sel_ready, y, y_valid, idx, wrap
  );

  modport slave (
    input  en, mode, sel, sel_valid,
    output sel_ready, y, y_valid, idx, wrap
  );

endinterface

// File: rtl/scan_prescaler.sv
// Step-tick generator for the scan modes.
//   clk   : clock
//   rst_n : synchronous active-low reset (count -> 0)
//   clr   : restart the count from 0 this cycle
//   run   : count this cycle
//   tick  : combinational, high on the cycle whose edge completes SCAN_DIV counts
module scan_prescaler #(
  parameter int unsigned SCAN_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] TermCnt = CntW'(SCAN_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d, cnt_eff;

  // A clear acts on the same cycle, so a freshly entered scan mode counts from 0.
  always_comb begin
    cnt_eff = clr ? '0 : cnt_q;
    tick    = run && (cnt_eff == TermCnt);
    cnt_d   = cnt_eff;
    if (run) begin
      cnt_d = tick ? '0 : cnt_eff + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/decoder_nxm_seq.sv
// Sequenced N-to-M one-hot decoder with decode, scan-up, scan-down and hold modes.
//   clk   : clock, all state on rising edge
//   rst_n : synchronous active-low reset
//   bus   : decoder_nxm_seq_if.slave
//           en/mode/sel/sel_valid in; sel_ready (combinational), y, y_valid, idx, wrap
//           (all registered) out
module decoder_nxm_seq
  import decoder_pkg::*;
#(
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned OUT_W      = 2 ** SEL_W,
  parameter int unsigned SCAN_DIV   = 1,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  decoder_nxm_seq_if.slave bus
);

  localparam logic [OUT_W-1:0] YIdle  = {OUT_W{ACTIVE_LOW}};
  localparam logic [SEL_W-1:0] IdxMax = SEL_W'(OUT_W - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] y_q, y_d;
  logic             y_valid_q;
  logic             wrap_q, wrap_d;
  mode_e            mode_q;
  logic             scan_run, scan_clr, scan_tick;

  // mode_q is the mode seen at the previous edge; a difference restarts the divider.
  assign scan_run = bus.en && (bus.mode == ModeScanUp || bus.mode == ModeScanDown);
  assign scan_clr = !bus.en || (bus.mode != mode_q);

  scan_prescaler #(
    .SCAN_DIV (SCAN_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (scan_clr),
    .run   (scan_run),
    .tick  (scan_tick)
  );

  assign bus.sel_ready = rst_n && bus.en && (bus.mode == ModeDecode);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wrap_d  = 1'b0;
    if (!bus.en) begin
      state_d = StIdle;
    end else begin
      unique case (bus.mode)
        ModeDecode: begin
          if (bus.sel_valid && bus.sel_ready) begin
            state_d = StActive;
            idx_d   = bus.sel;
          end
        end
        ModeScanUp: begin
          if (scan_tick) begin
            state_d = StActive;
            if (state_q == StIdle) begin
              idx_d = '0;
            end else begin
              // OUT_W is a power of two, so the add wraps modulo OUT_W.
              idx_d  = idx_q + SEL_W'(1);
              wrap_d = (idx_q == IdxMax);
            end
          end
        end
        ModeScanDown: begin
          if (scan_tick) begin
            state_d = StActive;
            if (state_q == StIdle) begin
              idx_d = IdxMax;
            end else begin
              idx_d  = idx_q - SEL_W'(1);
              wrap_d = (idx_q == '0);
            end
          end
        end
        ModeHold: begin
        end
      endcase
    end

    y_d = YIdle;
    if (state_d == StActive) begin
      y_d[idx_d] = ~ACTIVE_LOW;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      y_q       <= YIdle;
      y_valid_q <= 1'b0;
      wrap_q    <= 1'b0;
      mode_q    <= ModeDecode;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      y_q       <= y_d;
      y_valid_q <= (state_d == StActive);
      wrap_q    <= wrap_d;
      mode_q    <= bus.mode;
    end
  end

  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.idx     = idx_q;
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_decoder_nxm_seq.sv
// Scoreboard bench for decoder_nxm_seq: three instances with different parameters.
//   dut 0 : SEL_W=3, SCAN_DIV=1
//   dut 1 : SEL_W=2, SCAN_DIV=3
//   dut 2 : SEL_W=2, SCAN_DIV=1, ACTIVE_LOW=1
module tb_decoder_nxm_seq;
  import decoder_pkg::*;

  typedef struct {
    int          dut;
    string       name;
    logic [7:0]  y;
    logic        yv;
    logic [2:0]  idx;
    logic        wrap;
    logic        rdy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   done = 1'b0;

  initial forever #5 clk = ~clk;

  decoder_nxm_seq_if #(.SEL_W(3)) bus_a ();
  decoder_nxm_seq_if #(.SEL_W(2)) bus_b ();
  decoder_nxm_seq_if #(.SEL_W(2)) bus_c ();

  decoder_nxm_seq #(.SEL_W(3), .SCAN_DIV(1), .ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  decoder_nxm_seq #(.SEL_W(2), .SCAN_DIV(3), .ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );
  decoder_nxm_seq #(.SEL_W(2), .SCAN_DIV(1), .ACTIVE_LOW(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(bus_c)
  );

  // Watchdog: the stimulus must finish well within this bound.
  initial begin
    #20000;
    if (!done) begin
      n_errors++;
      $display("FAIL timeout: stimulus did not complete");
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
    end
  end

  // Monitor: compares every queued expectation against the addressed instance.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      logic [7:0] oy;
      logic       ov, ow, orr;
      logic [2:0] oi;
      e = sb_q.pop_front();
      case (e.dut)
        0: begin
          oy = 8'(bus_a.y); ov = bus_a.y_valid; oi = bus_a.idx;
          ow = bus_a.wrap; orr = bus_a.sel_ready;
        end
        1: begin
          oy = 8'(bus_b.y); ov = bus_b.y_valid; oi = 3'(bus_b.idx);
          ow = bus_b.wrap; orr = bus_b.sel_ready;
        end
        default: begin
          oy = 8'(bus_c.y); ov = bus_c.y_valid; oi = 3'(bus_c.idx);
          ow = bus_c.wrap; orr = bus_c.sel_ready;
        end
      endcase
      n_checks++;
      if (oy !== e.y || ov !== e.yv || oi !== e.idx || ow !== e.wrap || orr !== e.rdy) begin
        n_errors++;
        $display("FAIL %s dut%0d: got y=%h y_valid=%b idx=%0d wrap=%b sel_ready=%b, want y=%h y_valid=%b idx=%0d wrap=%b sel_ready=%b",
                 e.name, e.dut, oy, ov, oi, ow, orr, e.y, e.yv, e.idx, e.wrap, e.rdy);
      end
    end
  end

  // Expectation for the outputs after the next rising edge; sel_ready refers to the
  // inputs applied for that edge. Inputs change again just after the falling edge.
  task automatic edge_chk(input int dut, input string name, input logic [7:0] y,
                          input logic yv, input logic [2:0] idx, input logic wrap,
                          input logic rdy);
    exp_t e;
    @(posedge clk);
    e.dut = dut; e.name = name; e.y = y; e.yv = yv; e.idx = idx; e.wrap = wrap; e.rdy = rdy;
    sb_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  int         b_idx [16] = '{1, 1, 3, 3, 3, 2, 2, 2, 1, 1, 1, 0, 0, 0, 3, 3};
  logic [7:0] c_y   [5]  = '{8'h07, 8'h0B, 8'h0D, 8'h0E, 8'h07};
  int         c_idx [5]  = '{3, 2, 1, 0, 3};

  initial begin
    logic [7:0] one8;
    logic [7:0] ey;
    logic       ev;
    one8 = 8'd1;

    rst_n = 1'b0;
    bus_a.en = 1'b1; bus_a.mode = ModeScanUp; bus_a.sel = '0; bus_a.sel_valid = 1'b0;
    bus_b.en = 1'b0; bus_b.mode = ModeDecode; bus_b.sel = '0; bus_b.sel_valid = 1'b0;
    bus_c.en = 1'b1; bus_c.mode = ModeDecode; bus_c.sel = 2'd1; bus_c.sel_valid = 1'b1;

    // Reset wins over an active scan and a pending handshake.
    edge_chk(0, "reset_a", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    edge_chk(2, "reset_c", 8'h0F, 1'b0, 3'd0, 1'b0, 1'b0);

    // Direct reset-state check of the idle instance while reset is still asserted.
    n_checks++;
    if (bus_b.y !== 4'h0 || bus_b.y_valid !== 1'b0 || bus_b.idx !== 2'd0 ||
        bus_b.wrap !== 1'b0 || bus_b.sel_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state dut1: y=%h y_valid=%b idx=%0d wrap=%b sel_ready=%b",
               bus_b.y, bus_b.y_valid, bus_b.idx, bus_b.wrap, bus_b.sel_ready);
    end

    rst_n = 1'b1;
    bus_a.en = 1'b0;
    bus_c.en = 1'b0; bus_c.sel_valid = 1'b0;

    // Decode handshake and hold without a request.
    bus_b.en = 1'b1; bus_b.sel = 2'd2; bus_b.sel_valid = 1'b1;
    edge_chk(1, "decode_sel2", 8'h04, 1'b1, 3'd2, 1'b0, 1'b1);
    bus_b.sel_valid = 1'b0; bus_b.sel = 2'd1;
    edge_chk(1, "decode_hold1", 8'h04, 1'b1, 3'd2, 1'b0, 1'b1);
    edge_chk(1, "decode_hold2", 8'h04, 1'b1, 3'd2, 1'b0, 1'b1);
    bus_b.sel_valid = 1'b1;
    edge_chk(1, "decode_sel1", 8'h02, 1'b1, 3'd1, 1'b0, 1'b1);
    bus_b.sel_valid = 1'b0; bus_b.mode = ModeHold;
    edge_chk(1, "hold_not_ready", 8'h02, 1'b1, 3'd1, 1'b0, 1'b0);
    bus_b.en = 1'b0;
    edge_chk(1, "en_off_b", 8'h00, 1'b0, 3'd1, 1'b0, 1'b0);

    // Scan down from IDLE with a divide-by-3 step rate.
    bus_b.en = 1'b1; bus_b.mode = ModeScanDown;
    for (int k = 0; k < 16; k++) begin
      ev = (k >= 2);
      ey = ev ? (one8 << b_idx[k]) : 8'h00;
      edge_chk(1, "scan_down_div3", ey, ev, 3'(b_idx[k]), (k == 14), 1'b0);
    end
    bus_b.en = 1'b0;

    // Scan up from IDLE, one step per cycle, across the wrap up to idx 5.
    bus_a.en = 1'b1;
    for (int k = 0; k < 14; k++) begin
      edge_chk(0, "scan_up_div1", one8 << (k % 8), 1'b1, 3'(k % 8), (k == 8), 1'b0);
    end
    bus_a.mode = ModeHold;
    for (int k = 0; k < 4; k++) begin
      edge_chk(0, "hold_frozen", 8'h20, 1'b1, 3'd5, 1'b0, 1'b0);
    end
    bus_a.mode = ModeScanUp;
    edge_chk(0, "resume_up", 8'h40, 1'b1, 3'd6, 1'b0, 1'b0);
    rst_n = 1'b0;
    edge_chk(0, "reset_mid_scan", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    edge_chk(0, "scan_after_reset", 8'h01, 1'b1, 3'd0, 1'b0, 1'b0);
    bus_a.en = 1'b0;

    // Active-low outputs: decode, disable, then scan down through the wrap.
    bus_c.en = 1'b1; bus_c.mode = ModeDecode; bus_c.sel = 2'd1; bus_c.sel_valid = 1'b1;
    edge_chk(2, "al_decode_sel1", 8'h0D, 1'b1, 3'd1, 1'b0, 1'b1);
    bus_c.sel_valid = 1'b0; bus_c.en = 1'b0;
    edge_chk(2, "al_en_off", 8'h0F, 1'b0, 3'd1, 1'b0, 1'b0);
    bus_c.en = 1'b1; bus_c.mode = ModeScanDown;
    for (int k = 0; k < 5; k++) begin
      edge_chk(2, "al_scan_down", c_y[k], 1'b1, 3'(c_idx[k]), (k == 4), 1'b0);
    end

    @(negedge clk);
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
